cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the Tomasulo core: collects completed results from the execution-side producers (ALU, load/store buffer, branch unit) and serialises them onto the single `tag_renew`/`data_renew` broadcast consumed by the reservation station, LSB and ROB. Each producer has a small FIFO so that a cycle in which several units finish does not stall them. A round-robin pointer grants at most one broadcast per cycle.

---
 rtl/cdb_arbiter.sv | 86 ++++++++
 tb/tb_cdb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs serialised onto one CDB broadcast by a round-robin grant
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [1:0]              cdb_src,
  output logic                    busy
);
  localparam int AW = $clog2(DEPTH);
  logic [TAG_W-1:0]  tag_mem  [N_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem [N_SRC][DEPTH];
  logic [AW-1:0]     rd_ptr   [N_SRC];
  logic [AW-1:0]     wr_ptr   [N_SRC];
  logic [AW:0]       count    [N_SRC];
  logic [1:0]        rr_ptr, gnt;
  logic              gnt_valid;
  logic [N_SRC-1:0]  push, pop;
  // accept when not full; tag 0 is accepted but never stored
  always_comb begin
    src_ready = '0;
    push = '0;
    busy = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = count[i] < (AW+1)'(DEPTH);
      push[i] = src_valid[i] && src_ready[i] && src_tag[i*TAG_W +: TAG_W] != '0;
      busy = busy | (count[i] != '0);
    end
  end
  // scan from rr_ptr downward in offset so the smallest non-empty offset wins
  always_comb begin
    gnt = rr_ptr;
    gnt_valid = 1'b0;
    pop = '0;
    for (int k = N_SRC-1; k >= 0; k--)
      if (count[(int'(rr_ptr) + k) % N_SRC] != '0) begin
        gnt = 2'((int'(rr_ptr) + k) % N_SRC);
        gnt_valid = 1'b1;
      end
    if (gnt_valid) pop[gnt] = 1'b1;
  end
  // FIFO storage writes
  always_ff @(posedge clk)
    for (int i = 0; i < N_SRC; i++)
      if (!rst && !clear && rdy && push[i]) begin
        tag_mem[i][wr_ptr[i]]  <= src_tag[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= src_data[i*DATA_W +: DATA_W];
      end
  // pointers, counts, round-robin pointer and the registered broadcast
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < N_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr   <= '0;
      cdb_tag  <= '0;
      cdb_data <= '0;
      cdb_src  <= '0;
    end else if (rdy) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr[i] <= wr_ptr[i] + AW'(push[i]);
        rd_ptr[i] <= rd_ptr[i] + AW'(pop[i]);
        count[i]  <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end
      cdb_tag <= gnt_valid ? tag_mem[gnt][rd_ptr[gnt]] : '0;
      if (gnt_valid) begin
        cdb_data <= data_mem[gnt][rd_ptr[gnt]];
        cdb_src  <= gnt;
        rr_ptr   <= gnt == 2'(N_SRC-1) ? 2'd0 : gnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: queue-based reference model feeding a scoreboard checked by a negedge monitor
module tb_cdb_arbiter;
  localparam int N = 3, D = 4;
  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
    logic [1:0]  src;
  } rec_t;
  logic clk = 0, rst = 1, rdy = 1, clear = 0;
  logic [N-1:0] src_valid = '0;
  logic [N*5-1:0] src_tag = '0;
  logic [N*32-1:0] src_data = '0;
  logic [N-1:0] src_ready;
  logic [4:0] cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0] cdb_src;
  logic busy;
  int errs = 0, checks = 0;
  rec_t q[N][$];
  rec_t sb[$];
  rec_t last, e, rec;
  int rr = 0, kind = 0, jj;
  bit acc[N];
  bit g;

  cdb_arbiter #(.N_SRC(N), .DEPTH(D), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
    .src_ready(src_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: per-source queues, first non-empty source from rr wins, then rr moves past it
  always @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < N; i++) q[i].delete();
      rr = 0;
      kind = 0;
    end else if (rdy) begin
      kind = 1;
      for (int i = 0; i < N; i++)
        acc[i] = src_valid[i] && q[i].size() < D && src_tag[i*5 +: 5] != 0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        jj = (rr + k) % N;
        if (!g && q[jj].size() > 0) begin
          rec = q[jj].pop_front();
          sb.push_back(rec);
          rr = (jj + 1) % N;
          g = 1;
        end
      end
      for (int i = 0; i < N; i++)
        if (acc[i]) q[i].push_back('{src_tag[i*5 +: 5], src_data[i*32 +: 32], 2'(i)});
    end else
      kind = 2;
  end

  // monitor: compare broadcasts against the scoreboard and status against the model
  always @(negedge clk) begin
    if (kind == 0) begin
      chk("reset_tag", 32'(cdb_tag), 0);
      chk("reset_data", cdb_data, 0);
      chk("reset_src", 32'(cdb_src), 0);
      last = '0;
    end else if (kind == 1) begin
      if (cdb_tag != 0) begin
        if (sb.size() == 0) chk("unexpected_bcast", 32'(cdb_tag), 0);
        else begin
          e = sb.pop_front();
          chk("bcast_tag", 32'(cdb_tag), 32'(e.tag));
          chk("bcast_data", cdb_data, e.data);
          chk("bcast_src", 32'(cdb_src), 32'(e.src));
          last = e;
        end
      end else begin
        chk("missing_bcast", 32'(sb.size()), 0);
        sb.delete();
        chk("idle_data_hold", cdb_data, last.data);
        chk("idle_src_hold", 32'(cdb_src), 32'(last.src));
        last.tag = 0;
      end
    end else begin
      chk("stall_tag", 32'(cdb_tag), 32'(last.tag));
      chk("stall_data", cdb_data, last.data);
      chk("stall_src", 32'(cdb_src), 32'(last.src));
    end
    for (int i = 0; i < N; i++) chk("src_ready", 32'(src_ready[i]), 32'(q[i].size() < D));
    chk("busy", 32'(busy), 32'(q[0].size() + q[1].size() + q[2].size() != 0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int i, bit v, logic [4:0] t, logic [31:0] d);
    src_valid[i] = v;
    src_tag[i*5 +: 5] = t;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic idle();
    src_valid = '0;
    src_tag = '0;
    src_data = '0;
  endtask

  logic [4:0] tg[N];
  logic [N-1:0] r;
  int n1;
  bit saw;

  initial begin
    step(); step();
    rst = 0;
    // single result
    put(0, 1, 5, 32'h1234);
    step();
    idle();
    repeat (3) step();
    // simultaneous, starting from rr = 0
    clear = 1;
    step();
    clear = 0;
    put(0, 1, 3, 32'hA0); put(1, 1, 4, 32'hA1); put(2, 1, 6, 32'hA2);
    step();
    idle();
    repeat (5) step();
    // fairness and pointer wrap
    for (int i = 0; i < N; i++) tg[i] = 5'(1 + i * 10);
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) put(i, 1, tg[i], {8'(i), 24'(c)});
      r = src_ready;
      step();
      for (int i = 0; i < N; i++) if (r[i]) tg[i] = tg[i] == 31 ? 5'd1 : tg[i] + 5'd1;
    end
    idle();
    repeat (15) step();
    // backpressure on source 1
    n1 = 0;
    saw = 0;
    for (int c = 0; c < 40 && n1 < 6; c++) begin
      put(0, 1, 5'($urandom_range(31, 1)), $urandom);
      put(2, 1, 5'($urandom_range(31, 1)), $urandom);
      put(1, 1, 5'(n1 + 1), 32'h100 + n1);
      r = src_ready;
      if (!r[1]) saw = 1;
      step();
      if (r[1]) n1++;
    end
    if (!src_ready[1]) saw = 1;
    chk("bp_all_accepted", n1, 6);
    chk("bp_saw_full", 32'(saw), 1);
    idle();
    repeat (20) step();
    // empty-tag drop
    put(2, 1, 0, 32'hDEAD);
    repeat (3) step();
    idle();
    step();
    // clear with entries queued while source 0 pushes
    put(0, 1, 7, 32'hC0); put(1, 1, 8, 32'hC1); put(2, 1, 10, 32'hC2);
    step();
    idle();
    put(0, 1, 9, 32'hC3);
    clear = 1;
    step();
    clear = 0;
    idle();
    repeat (3) step();
    // stall mid-stream
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < N; i++) put(i, 1, 5'(11 + c * 3 + i), 32'h500 + c * 3 + i);
      step();
    end
    rdy = 0;
    repeat (3) step();
    rdy = 1;
    idle();
    repeat (10) step();
    // randomized traffic with occasional stalls and flushes
    for (int c = 0; c < 300; c++) begin
      rdy = $urandom_range(9) != 0;
      clear = $urandom_range(49) == 0;
      for (int i = 0; i < N; i++)
        put(i, 1'($urandom_range(1)), $urandom_range(7) == 0 ? 5'd0 : 5'($urandom_range(31, 1)), $urandom);
      step();
    end
    rdy = 1;
    clear = 0;
    idle();
    for (int c = 0; c < 50 && busy; c++) step();
    step();
    chk("drain_busy", 32'(busy), 0);
    chk("sb_left", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
